// File: rtl/feed_forward_input_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feed_forward_input_layer_sequencer_pkg
// Description : Shared definitions for the input-layer sequencer slice:
//               default widths, sequencer state encoding, the weight address
//               helper (node * NUM_INPUTS + element) and IEEE-754 single
//               precision constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package feed_forward_input_layer_sequencer_pkg;

    localparam int C_DATA_WIDTH_DEFAULT = 32;
    localparam int C_NUM_INPUTS_DEFAULT = 3;
    localparam int C_NUM_NODES_DEFAULT  = 4;
    localparam int C_ADDR_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } seq_state_t;

    // Flat weight-bank address of (node, element).
    function automatic int weight_addr(input int node, input int elem, input int num_inputs);
        return node * num_inputs + elem;
    endfunction

    // IEEE-754 single precision constants.
    localparam logic [31:0] C_FP32_ONE     = 32'h3F80_0000;
    localparam logic [31:0] C_FP32_TWO     = 32'h4000_0000;
    localparam logic [31:0] C_FP32_THREE   = 32'h4040_0000;
    localparam logic [31:0] C_FP32_FOUR    = 32'h4080_0000;
    localparam logic [31:0] C_FP32_FIVE    = 32'h40A0_0000;
    localparam logic [31:0] C_FP32_SIX     = 32'h40C0_0000;
    localparam logic [31:0] C_FP32_SEVEN   = 32'h40E0_0000;
    localparam logic [31:0] C_FP32_EIGHT   = 32'h4100_0000;
    // Adding this to a normal float's bit pattern doubles its value.
    localparam logic [31:0] C_FP32_EXP_LSB = 32'h0080_0000;

endpackage
`default_nettype wire

// File: rtl/feed_forward_input_layer_sequencer_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : input_layer_weight_bank
// Description : Weight register file, NUM_NODES * NUM_INPUTS words. One
//               synchronous write port; NUM_NODES combinational read ports
//               that all use the same element index, so every node sees its
//               own weight for the element currently being streamed.
// Ports       : clk, rst_n         - clock, async active-low reset (clears bank)
//               i_we/i_addr/i_wdata - write port; out-of-range addresses ignored
//               i_idx               - element index shared by all read ports
//               o_rdata             - node n weight at [n*DATA_WIDTH +: DATA_WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module input_layer_weight_bank
    import feed_forward_input_layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH_DEFAULT,
    parameter int NUM_INPUTS = C_NUM_INPUTS_DEFAULT,
    parameter int NUM_NODES  = C_NUM_NODES_DEFAULT,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH_DEFAULT,
    parameter int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-1:0]           i_addr,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    input  logic [IDX_WIDTH-1:0]            i_idx,
    output logic [NUM_NODES*DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH  = NUM_NODES * NUM_INPUTS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_addr_ok;
    logic [MEM_AW-1:0]     w_waddr;

    // The range test uses the full address so that high bits cannot alias
    // an out-of-range write onto a low entry.
    assign w_addr_ok = (64'(i_addr) < 64'(DEPTH));
    assign w_waddr   = i_addr[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_addr_ok) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_read
        localparam int BASE = weight_addr(n, 0, NUM_INPUTS);
        logic [MEM_AW-1:0] w_ridx;

        assign w_ridx = MEM_AW'(BASE) + MEM_AW'(i_idx);
        assign o_rdata[n*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ridx];
    end

endmodule
`default_nettype wire

// File: rtl/feed_forward_input_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : feed_forward_input_layer_sequencer
// Description : Accepts one state vector per valid/ready handshake and
//               streams it one element per cycle, broadcasting the element
//               and each node's matching weight. Vectors chain back-to-back
//               when the next one is accepted on the last beat.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               i_valid, i_data, o_ready     - vector handshake
//               i_weight_we/addr/data        - weight bank write port
//               o_valid, o_data, o_weight    - registered beat outputs
//               o_last                       - final beat of a vector
//               o_busy                       - streaming in progress (= o_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module feed_forward_input_layer_sequencer
    import feed_forward_input_layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH_DEFAULT,
    parameter int NUM_INPUTS = C_NUM_INPUTS_DEFAULT,
    parameter int NUM_NODES  = C_NUM_NODES_DEFAULT,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
    output logic                             o_ready,
    input  logic                             i_weight_we,
    input  logic [ADDR_WIDTH-1:0]            i_weight_addr,
    input  logic [DATA_WIDTH-1:0]            i_weight_data,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [NUM_NODES*DATA_WIDTH-1:0]  o_weight,
    output logic                             o_last,
    output logic                             o_busy
);

    localparam int                   IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_WIDTH-1:0] C_IDX_LAST = IDX_WIDTH'(NUM_INPUTS - 1);

    seq_state_t                      r_state;
    seq_state_t                      w_state_next;
    logic [IDX_WIDTH-1:0]            r_idx;
    logic [IDX_WIDTH-1:0]            w_idx_next;
    logic [DATA_WIDTH-1:0]           r_vec [NUM_INPUTS];

    logic                            w_beat;
    logic                            w_at_last;
    logic                            w_accept;
    logic [NUM_NODES*DATA_WIDTH-1:0] w_bank_rdata;

    logic                            r_valid;
    logic                            r_last;
    logic [DATA_WIDTH-1:0]           r_data;
    logic [NUM_NODES*DATA_WIDTH-1:0] r_weight;

    // ------------------------------------------------------------------
    // Weight bank, read at the element currently being streamed
    // ------------------------------------------------------------------
    input_layer_weight_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_NODES  (NUM_NODES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_weight_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (i_weight_we),
        .i_addr  (i_weight_addr),
        .i_wdata (i_weight_data),
        .i_idx   (r_idx),
        .o_rdata (w_bank_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Ready opens on the last beat as well as in IDLE,
    // which is what lets a queued vector follow without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_beat       = (r_state == ST_STREAM);
        w_at_last    = (r_idx == C_IDX_LAST);
        o_ready      = (r_state == ST_IDLE) || (w_beat && w_at_last);
        w_accept     = i_valid && o_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_STREAM;
                    w_idx_next   = '0;
                end
            end
            ST_STREAM: begin
                if (w_at_last) begin
                    w_state_next = w_accept ? ST_STREAM : ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + IDX_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Vector register; a reload on the last beat is safe because that
    // beat's element is captured into r_data on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                r_vec[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                r_vec[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat output registers. Data and weights hold their last values
    // once streaming stops. Weights are sampled from the bank's current
    // contents, so a write landing on the same edge shows up one beat later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
            r_weight <= '0;
        end else begin
            r_valid <= w_beat;
            r_last  <= w_beat && w_at_last;
            if (w_beat) begin
                r_data   <= r_vec[r_idx];
                r_weight <= w_bank_rdata;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_busy   = r_valid;
    assign o_last   = r_last;
    assign o_data   = r_data;
    assign o_weight = r_weight;

endmodule
`default_nettype wire

// File: tb/tb_feed_forward_input_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_feed_forward_input_layer_sequencer
// Description : Self-checking bench for feed_forward_input_layer_sequencer:
//               cycle table for single/back-to-back/ignored-request streams,
//               hand sequences for weight-write collision, out-of-range
//               writes and asynchronous reset, then random traffic against
//               a behavioural model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feed_forward_input_layer_sequencer;
    import feed_forward_input_layer_sequencer_pkg::*;

    localparam int DW    = 32;
    localparam int NI    = 3;
    localparam int NN    = 4;
    localparam int AW    = 8;
    localparam int DEPTH = NN * NI;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic [NI*DW-1:0] i_data;
    logic             o_ready;
    logic             i_weight_we;
    logic [AW-1:0]    i_weight_addr;
    logic [DW-1:0]    i_weight_data;
    logic             o_valid;
    logic [DW-1:0]    o_data;
    logic [NN*DW-1:0] o_weight;
    logic             o_last;
    logic             o_busy;

    always #5 clk = ~clk;

    feed_forward_input_layer_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .NUM_NODES  (NN),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .i_weight_we   (i_weight_we),
        .i_weight_addr (i_weight_addr),
        .i_weight_data (i_weight_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_weight      (o_weight),
        .o_last        (o_last),
        .o_busy        (o_busy)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mw [DEPTH];

    typedef struct {
        logic         vld;
        logic [95:0]  data;
        logic         exp_ready;
        logic         exp_valid;
        logic [31:0]  exp_data;
        logic         exp_last;
        logic [127:0] exp_weight;
    } row_t;

    row_t tbl [19];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_w(input int j);
        logic [127:0] r;
        for (int n = 0; n < NN; n++) begin
            r[n*DW +: DW] = mw[n*NI + j];
        end
        return r;
    endfunction

    function automatic row_t mk(input logic vld, input logic [95:0] d, input logic rdy,
                                input logic v, input logic [31:0] od, input logic l,
                                input logic [127:0] w);
        row_t r;
        r.vld = vld; r.data = d; r.exp_ready = rdy; r.exp_valid = v;
        r.exp_data = od; r.exp_last = l; r.exp_weight = w;
        return r;
    endfunction

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        i_weight_we   = 1'b1;
        i_weight_addr = addr;
        i_weight_data = data;
        step();
        i_weight_we = 1'b0;
        if (int'(addr) < DEPTH) mw[addr] = data;
    endtask

    // Accept one vector from IDLE and check its three beats and the idle cycle after.
    task automatic run_vector(input logic [95:0] v, input string tag);
        i_valid = 1'b1;
        i_data  = v;
        check({tag, "_ready"}, 128'(o_ready), 128'(1'b1));
        step();
        i_valid = 1'b0;
        for (int j = 0; j < NI; j++) begin
            step();
            check({tag, "_valid"}, 128'(o_valid), 128'(1'b1));
            check({tag, "_data"},  128'(o_data),  128'(v[j*DW +: DW]));
            check({tag, "_wgt"},   o_weight,      exp_w(j));
            check({tag, "_last"},  128'(o_last),  128'(j == NI - 1));
        end
        step();
        check({tag, "_idle_valid"}, 128'(o_valid), 128'(1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0]  v0, v1, v2, vr;
        logic [127:0] wl, e_w;
        logic [31:0]  e_data, wd;
        logic [AW-1:0] wa;
        logic         e_last, beat, acc, vld, we, e_rdy;
        int           m_state, m_idx;
        logic [31:0]  m_vec [NI];

        v0 = '0;
        v1 = {C_FP32_THREE, C_FP32_TWO, C_FP32_ONE};
        v2 = {C_FP32_SEVEN, C_FP32_SIX, C_FP32_FIVE};
        wl = {C_FP32_EIGHT, C_FP32_FOUR, C_FP32_TWO, C_FP32_ONE};

        //           vld  data rdy  vld  o_data        last  weight
        tbl[0]  = mk(1'b1, v1, 1'b1, 1'b0, 32'h0,        1'b0, 128'h0);
        tbl[1]  = mk(1'b0, v0, 1'b0, 1'b1, C_FP32_ONE,   1'b0, wl);
        tbl[2]  = mk(1'b0, v0, 1'b0, 1'b1, C_FP32_TWO,   1'b0, wl);
        tbl[3]  = mk(1'b0, v0, 1'b1, 1'b1, C_FP32_THREE, 1'b1, wl);
        tbl[4]  = mk(1'b0, v0, 1'b1, 1'b0, C_FP32_THREE, 1'b0, wl);
        tbl[5]  = mk(1'b1, v1, 1'b1, 1'b0, C_FP32_THREE, 1'b0, wl);
        tbl[6]  = mk(1'b1, v2, 1'b0, 1'b1, C_FP32_ONE,   1'b0, wl);
        tbl[7]  = mk(1'b1, v2, 1'b0, 1'b1, C_FP32_TWO,   1'b0, wl);
        tbl[8]  = mk(1'b1, v2, 1'b1, 1'b1, C_FP32_THREE, 1'b1, wl);
        tbl[9]  = mk(1'b0, v0, 1'b0, 1'b1, C_FP32_FIVE,  1'b0, wl);
        tbl[10] = mk(1'b0, v0, 1'b0, 1'b1, C_FP32_SIX,   1'b0, wl);
        tbl[11] = mk(1'b0, v0, 1'b1, 1'b1, C_FP32_SEVEN, 1'b1, wl);
        tbl[12] = mk(1'b0, v0, 1'b1, 1'b0, C_FP32_SEVEN, 1'b0, wl);
        tbl[13] = mk(1'b1, v1, 1'b1, 1'b0, C_FP32_SEVEN, 1'b0, wl);
        tbl[14] = mk(1'b0, v0, 1'b0, 1'b1, C_FP32_ONE,   1'b0, wl);
        tbl[15] = mk(1'b1, v2, 1'b0, 1'b1, C_FP32_TWO,   1'b0, wl);
        tbl[16] = mk(1'b0, v0, 1'b1, 1'b1, C_FP32_THREE, 1'b1, wl);
        tbl[17] = mk(1'b0, v0, 1'b1, 1'b0, C_FP32_THREE, 1'b0, wl);
        tbl[18] = mk(1'b0, v0, 1'b1, 1'b0, C_FP32_THREE, 1'b0, wl);

        for (int i = 0; i < DEPTH; i++) mw[i] = '0;
        rst_n         = 1'b0;
        i_valid       = 1'b0;
        i_data        = '0;
        i_weight_we   = 1'b0;
        i_weight_addr = '0;
        i_weight_data = '0;

        // Reset state
        #3;
        check("rst_valid",  128'(o_valid), 128'(1'b0));
        check("rst_last",   128'(o_last),  128'(1'b0));
        check("rst_busy",   128'(o_busy),  128'(1'b0));
        check("rst_data",   128'(o_data),  128'h0);
        check("rst_weight", o_weight,      128'h0);
        check("rst_ready",  128'(o_ready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Weight load: node n gets 1.0 * 2^n for every element
        for (int n = 0; n < NN; n++) begin
            for (int j = 0; j < NI; j++) begin
                wr(AW'(weight_addr(n, j, NI)), C_FP32_ONE + 32'(n) * C_FP32_EXP_LSB);
            end
        end

        // Cycle table: single vector, back-to-back pair, ignored request
        for (int i = 0; i < 19; i++) begin
            i_valid = tbl[i].vld;
            i_data  = tbl[i].data;
            check($sformatf("tbl%0d_ready", i), 128'(o_ready), 128'(tbl[i].exp_ready));
            step();
            check($sformatf("tbl%0d_valid", i), 128'(o_valid), 128'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_busy", i),  128'(o_busy),  128'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_data", i),  128'(o_data),  128'(tbl[i].exp_data));
            check($sformatf("tbl%0d_last", i),  128'(o_last),  128'(tbl[i].exp_last));
            check($sformatf("tbl%0d_wgt", i),   o_weight,      tbl[i].exp_weight);
        end

        // Write to node 1 element 1 on the edge that registers beat 1
        i_valid = 1'b1;
        i_data  = v1;
        step();
        i_valid = 1'b0;
        step();
        check("col_b0_wgt", o_weight, exp_w(0));
        i_weight_we   = 1'b1;
        i_weight_addr = AW'(weight_addr(1, 1, NI));
        i_weight_data = C_FP32_FIVE;
        step();
        i_weight_we = 1'b0;
        check("col_b1_old_wgt", 128'(o_weight[1*DW +: DW]), 128'(C_FP32_TWO));
        check("col_b1_wgt", o_weight, exp_w(1));
        mw[weight_addr(1, 1, NI)] = C_FP32_FIVE;
        step();
        check("col_b2_wgt", o_weight, exp_w(2));
        step();
        // Out-of-range writes, including ones whose low bits alias real entries
        wr(8'd12, 32'hDEAD_BEEF);
        wr(8'd16, 32'hBAD0_0016);
        wr(8'd255, 32'hBAD0_00FF);
        i_valid = 1'b1;
        i_data  = v2;
        step();
        i_valid = 1'b0;
        step();
        check("new_b0_wgt", o_weight, exp_w(0));
        step();
        check("new_b1_n1_wgt", 128'(o_weight[1*DW +: DW]), 128'(C_FP32_FIVE));
        check("new_b1_wgt", o_weight, exp_w(1));
        step();
        check("new_b2_wgt", o_weight, exp_w(2));
        step();
        run_vector(v1, "oor");

        // Asynchronous reset during beat 1
        i_valid = 1'b1;
        i_data  = v2;
        step();
        i_valid = 1'b0;
        step();
        step();
        check("pre_rst_valid", 128'(o_valid), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  128'(o_valid), 128'(1'b0));
        check("arst_last",   128'(o_last),  128'(1'b0));
        check("arst_data",   128'(o_data),  128'h0);
        check("arst_weight", o_weight,      128'h0);
        check("arst_ready",  128'(o_ready), 128'(1'b1));
        for (int i = 0; i < DEPTH; i++) mw[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vector(v2, "post_rst");

        // Random traffic with concurrent weight writes
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom);
        m_state = 0;
        m_idx   = 0;
        for (int k = 0; k < NI; k++) m_vec[k] = '0;
        for (int c = 0; c < 200; c++) begin
            vld = ($urandom_range(0, 3) != 0);
            vr  = {$urandom, $urandom, $urandom};
            we  = ($urandom_range(0, 3) == 0);
            wa  = AW'($urandom_range(0, 15));
            wd  = $urandom;
            i_valid       = vld;
            i_data        = vr;
            i_weight_we   = we;
            i_weight_addr = wa;
            i_weight_data = wd;
            e_rdy = (m_state == 0) || (m_idx == NI - 1);
            check("rnd_ready", 128'(o_ready), 128'(e_rdy));
            beat   = (m_state == 1);
            e_data = m_vec[m_idx];
            e_w    = exp_w(m_idx);
            e_last = (m_idx == NI - 1);
            acc    = vld && e_rdy;
            step();
            if (we && int'(wa) < DEPTH) mw[wa] = wd;
            check("rnd_valid", 128'(o_valid), 128'(beat));
            if (beat) begin
                check("rnd_data", 128'(o_data), 128'(e_data));
                check("rnd_wgt",  o_weight,     e_w);
                check("rnd_last", 128'(o_last), 128'(e_last));
            end
            if (m_state == 1 && m_idx < NI - 1) begin
                m_idx++;
            end else if (acc) begin
                m_state = 1;
                m_idx   = 0;
                for (int k = 0; k < NI; k++) m_vec[k] = vr[k*DW +: DW];
            end else begin
                m_state = 0;
                m_idx   = 0;
            end
        end
        i_valid     = 1'b0;
        i_weight_we = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/feed_forward_input_layer_sequencer.md
# feed_forward_input_layer_sequencer

Upstream feeder for the input-layer feed-forward nodes. Accepts one complete state vector per handshake, holds a weight bank for every node, and streams the vector one element per cycle. Each cycle it broadcasts the current element to all nodes, together with that node's matching weight. The nodes' multiply → 3-input accumulate → leaky-ReLU pipeline receives exactly NUM_INPUTS consecutive valid beats per vector.

## Interface
- DATA_WIDTH, 32, IEEE-754 single word width
- NUM_INPUTS, 3, elements per state vector (beats per vector)
- NUM_NODES, 4, nodes fed in parallel
- ADDR_WIDTH, 8, weight write address width (≥ clog2(NUM_NODES·NUM_INPUTS))
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  state vector present on i_data
- i_data  in  NUM_INPUTS·DATA_WIDTH  element k at bits [k·DW +: DW]
- o_ready  out  1  vector accepted when i_valid & o_ready at a rising edge
- i_weight_we  in  1  weight write strobe
- i_weight_addr  in  ADDR_WIDTH  node·NUM_INPUTS + element
- i_weight_data  in  DATA_WIDTH  weight value
- o_valid  out  1  beat valid
- o_data  out  DATA_WIDTH  current element, broadcast to all nodes
- o_weight  out  NUM_NODES·DATA_WIDTH  weight for node n at [n·DW +: DW]
- o_last  out  1  final beat of a vector
- o_busy  out  1  streaming in progress

## Operation
- States: IDLE, STREAM. Beat counter idx ∈ [0, NUM_INPUTS-1].
- IDLE: o_ready=1. On accept, latch i_data into the vector register, set idx=0, go to STREAM.
- STREAM: each cycle drive o_valid=1, o_data=vec[idx], o_weight[n]=W[n·NUM_INPUTS+idx], o_last=(idx==NUM_INPUTS-1). Then idx increments.
- o_ready=1 in STREAM only while idx==NUM_INPUTS-1. An accept on that cycle reloads the vector, sets idx=0, and stays in STREAM, so vectors stream back-to-back with no bubble. With no accept on the last beat, return to IDLE.
- i_valid while o_ready=0 is ignored. Upstream holds the request; the block has no internal queue.
- Weight bank: NUM_NODES·NUM_INPUTS words. Writes are accepted in any state. An address ≥ NUM_NODES·NUM_INPUTS is ignored.
- Write/read collision: a beat registered on the same edge as a write to its address carries the old weight. The new weight takes effect from the next beat.
- The block performs no arithmetic on data. Words pass through bit-exact.

## Timing
- All outputs are registered.
- Reset values: o_valid=0, o_last=0, o_busy=0, o_data=0, o_weight=0, idx=0, state=IDLE, weight bank all zero. o_ready=1 after reset (combinational from state/idx).
- Latency: accept at edge k → beat 0 visible after edge k+1, beat j after edge k+1+j. o_last is high after edge k+NUM_INPUTS.
- Throughput: one vector per NUM_INPUTS cycles sustained.
- o_busy equals o_valid.
- Reset asserted mid-vector: outputs clear immediately (asynchronously) and the remaining beats are dropped. The weight bank also clears, and software reloads it.
- After the final beat with no new accept, o_valid=0 on the next cycle and o_data/o_weight hold their last values.

## Structure
- Shared package: DATA_WIDTH default, state encoding (IDLE/STREAM), weight address helper (node·NUM_INPUTS+elem), and the IEEE-754 constants used by benches (1.0=0x3F800000).
- One sub-module: input_layer_weight_bank. It is a register file with one synchronous write port and NUM_NODES parallel combinational read ports indexed by idx.
- FSM, counter and vector register live in the top.

## Test plan
- Reset, then load weights W[n·3+j]=0x3F800000 + n·0x00800000 (1.0, 2.0, 4.0, 8.0 per node). Send vector {0x3F800000, 0x40000000, 0x40400000} → beats 1.0, 2.0, 3.0 on o_data at edges k+1..k+3. o_weight[n] is constant per node. o_last only on the 3rd beat.
- Two vectors with i_valid held continuously → 6 contiguous o_valid beats. o_ready is high only on the 3rd beat of the first vector. There is no gap between vectors.
- i_valid pulsed during beat 0 of a stream → ignored. Beat count stays 3 and no extra beats appear.
- Write node 1 element 1 to 0x40A00000 on the same edge that registers beat 1 → that beat shows the old weight. The next vector's beat 1 shows 5.0. Write to address 12 (out of range) → no change anywhere.
- Assert rst_n low during beat 1 → o_valid, o_last, o_data and o_weight drop to 0 without a clock edge. After release, o_ready=1 and the first accept streams from beat 0.
- Randomised back-to-back vectors plus random weight writes, checked against a scoreboard model for every beat's o_data/o_weight/o_last.
